// File: rtl/gf251_inv_if.sv
// Request/result bundle for the GF(251) inverter.
interface gf251_inv_if;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] o_c;
  logic       o_done;
  logic       o_zero;
  logic       o_busy;

  modport master (
    output i_start, i_a,
    input  o_c, o_done, o_zero, o_busy
  );

  modport slave (
    input  i_start, i_a,
    output o_c, o_done, o_zero, o_busy
  );
endinterface

// File: rtl/gf251_inv.sv
// Sequential GF(251) inverter: o_c = a^249 mod 251 (Fermat), using one shared
// 8x8 multiplier followed by a 3-stage Barrett reduction.
module gf251_inv (
  input  logic        i_clk,
  input  logic        i_rst,
  gf251_inv_if.slave  bus
);

  localparam int unsigned OP_LAT = 4;
  localparam logic [7:0]  EXP    = 8'd249;  // 8'b1111_1001
  localparam logic [7:0]  PRIME  = 8'd251;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  r_q, r_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;
  logic [9:0]  q_q, q_d;
  logic [17:0] t_q, t_d;
  logic [7:0]  c_q, c_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;

  logic [7:0]  mul_y;
  logic [25:0] p262;
  logic [8:0]  c9;
  logic [7:0]  red;

  // Multiply/reduce datapath. The stages run every cycle; the operands stay
  // constant for a whole step, so after OP_LAT edges p_q and t_q belong to
  // the same product and red is the reduced result.
  always_comb begin
    mul_y = (state_q == MUL) ? a_q : r_q;
    p_d   = {8'd0, r_q} * {8'd0, mul_y};
    p262  = {10'd0, p_q} * 26'd262;
    q_d   = p262[25:16];
    t_d   = {8'd0, q_q} * 18'd251;
    c9    = p_q[8:0] - t_q[8:0];
    red   = c9[8] ? (c9[7:0] + PRIME) : c9[7:0];
  end

  // Control FSM: next state, exponent walk and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          a_d     = (bus.i_a >= PRIME) ? (bus.i_a - PRIME) : bus.i_a;
          state_d = LOAD;
        end
      end
      LOAD: begin
        r_d     = a_q;
        k_d     = 3'd6;
        cnt_d   = '0;
        state_d = SQR;
      end
      SQR, MUL: begin
        if (cnt_q == 2'(OP_LAT - 1)) begin
          cnt_d = '0;
          r_d   = red;
          if (state_q == SQR && EXP[k_q]) begin
            state_d = MUL;
          end else if (k_q == 3'd0) begin
            state_d = DONE;
          end else begin
            k_d     = k_q - 3'd1;
            state_d = SQR;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        c_d     = r_q;
        zero_d  = (a_q == 8'd0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      t_q     <= t_d;
      c_q     <= c_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.o_c    = c_q;
  assign bus.o_done = done_q;
  assign bus.o_zero = zero_q;
  assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_gf251_inv.sv
// Self-checking bench for gf251_inv against a brute-force inverse model.
module tb_gf251_inv;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gf251_inv_if bus ();

  gf251_inv dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: canonicalise, then search for the multiplicative inverse.
  function automatic int ref_inv(input int a);
    int x;
    x = a % 251;
    if (x == 0) return 0;
    for (int b = 1; b < 251; b++)
      if ((x * b) % 251 == 1) return b;
    return -1;
  endfunction

  task automatic run_one(input logic [7:0] a, output logic [7:0] c);
    int n;
    bit seen;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_done) seen = 1'b1;
      else check("busy_frame", bus.o_busy, 1);
    end
    check("done_seen", seen, 1);
    check("latency", n, 50);
    check("o_c", bus.o_c, ref_inv(a));
    check("o_zero", bus.o_zero, (a % 251 == 0) ? 1 : 0);
    check("busy_at_done", bus.o_busy, 0);
    c = bus.o_c;
    @(posedge clk); #1;
    check("done_pulse", bus.o_done, 0);
    check("held_o_c", bus.o_c, ref_inv(a));
  endtask

  initial begin
    logic [7:0] c;
    int n;
    int t1, t2;
    bit seen;
    logic [7:0] dir_a [8] = '{8'd2, 8'd3, 8'd7, 8'd1, 8'd250, 8'd0, 8'd251, 8'd253};
    logic [7:0] dir_c [8] = '{8'd126, 8'd84, 8'd36, 8'd1, 8'd250, 8'd0, 8'd0, 8'd126};

    bus.i_start = 1'b0;
    bus.i_a     = '0;
    #12;
    check("rst_o_c", bus.o_c, 0);
    check("rst_o_done", bus.o_done, 0);
    check("rst_o_zero", bus.o_zero, 0);
    check("rst_o_busy", bus.o_busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a request aborts it silently.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'd2;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.o_busy, 0);
    check("abort_done", bus.o_done, 0);
    check("abort_o_c", bus.o_c, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.o_done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    // Directed values.
    for (int i = 0; i < 8; i++) begin
      run_one(dir_a[i], c);
      check("directed", c, dir_c[i]);
    end

    // Second start while busy is dropped.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'd2;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n = 0;
    repeat (9) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'd3;
    @(posedge clk); #1;
    n++;
    bus.i_start = 1'b0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_done) seen = 1'b1;
    end
    check("drop_seen", seen, 1);
    check("drop_latency", n, 50);
    check("drop_o_c", bus.o_c, 126);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.o_done) seen = 1'b1;
    end
    check("drop_no_second", seen, 0);

    // i_start held high: restart every 51 cycles, i_a sampled per acceptance.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'd5;
    @(posedge clk); #1;
    bus.i_a = 8'd6;
    n = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_done) begin
        if (t1 < 0) begin
          t1 = n;
          check("held_first", bus.o_c, ref_inv(5));
        end else begin
          t2 = n;
          bus.i_start = 1'b0;
          check("held_second", bus.o_c, ref_inv(6));
        end
      end
    end
    bus.i_start = 1'b0;
    check("held_first_lat", t1, 50);
    check("held_period", t2 - t1, 51);
    repeat (3) @(posedge clk);
    #1;
    check("held_idle", bus.o_busy, 0);

    // Random operands over the full 8-bit input range.
    repeat (20) run_one(8'($urandom_range(0, 255)), c);

    // Exhaustive sweep of nonzero residues.
    for (int a = 1; a <= 250; a++) begin
      run_one(8'(a), c);
      check("inv_prod", (a * int'(c)) % 251, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
